// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C widths, bus levels and target FSM states
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    // Level seen on SDA during the acknowledge clock
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchroniser with edge and START/STOP detection
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Two-flop synchroniser plus one history flop per pin; idle bus is high
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    // Registered bus events; sda_s is delayed to line up with scl_rise
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda_s    <= 1'b1;
        end else begin
            scl_rise <= scl_sync[1] & ~scl_d;
            scl_fall <= ~scl_sync[1] & scl_d;
            start    <= scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
            stop     <= scl_sync[1] & scl_d & ~sda_d & sda_sync[1];
            sda_s    <= sda_sync[1];
        end
    end

endmodule

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing a pointer-addressed register bank
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h2A,
    parameter int                    NREGS       = 4,
    parameter logic [I2C_BYTE_W-1:0] RESET_VAL   = 8'h00
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scl,
    input  logic                          sda_in,
    output logic                          sda_out,
    output logic                          ctrl,
    output logic [I2C_BYTE_W*NREGS-1:0]   reg_q,
    output logic                          wr_stb,
    output logic [$clog2(NREGS)-1:0]      wr_idx
);

    localparam int PW = $clog2(NREGS);

    logic                  scl_rise;
    logic                  scl_fall;
    logic                  start;
    logic                  stop;
    logic                  sda_s;

    i2c_state_t            state;
    logic [2:0]            bit_cnt;
    logic                  got_bit;
    logic                  rw;
    logic [I2C_BYTE_W-1:0] shreg;
    logic [PW-1:0]         ptr;
    logic [I2C_BYTE_W-1:0] regs [NREGS];

    logic [I2C_BYTE_W-1:0] shift_in;
    logic [I2C_BYTE_W-1:0] rd_byte;
    logic [PW-1:0]         ptr_next;
    logic                  ptr_ok;

    i2c_bus_sync u_bus_sync (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    // Open-drain: the pad only ever drives low, ctrl is its enable
    assign sda_out  = 1'b0;

    assign shift_in = {shreg[I2C_BYTE_W-2:0], sda_s};
    assign rd_byte  = regs[ptr];
    assign ptr_next = (ptr == PW'(NREGS - 1)) ? '0 : ptr + PW'(1);
    assign ptr_ok   = ({1'b0, shreg} < 9'(NREGS));

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg_q
            assign reg_q[I2C_BYTE_W*gi +: I2C_BYTE_W] = regs[gi];
        end
    endgenerate

    // Protocol FSM: bit capture, ACK/data drive on SCL fall, pointer and register writes
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            got_bit <= 1'b0;
            rw      <= 1'b0;
            shreg   <= '0;
            ptr     <= '0;
            ctrl    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_idx  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            wr_stb <= 1'b0;
            if (stop) begin
                // Any partial byte is dropped; pointer survives for the next transfer
                state   <= ST_IDLE;
                ctrl    <= 1'b0;
                bit_cnt <= 3'd0;
                got_bit <= 1'b0;
            end else if (start) begin
                state   <= ST_ADDR;
                ctrl    <= 1'b0;
                bit_cnt <= 3'd0;
                got_bit <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        ctrl <= 1'b0;
                    end

                    ST_ADDR, ST_PTR, ST_WDATA: begin
                        if (scl_rise) begin
                            shreg   <= shift_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                got_bit <= 1'b1;
                                if (state == ST_WDATA) begin
                                    regs[ptr] <= shift_in;
                                    wr_stb    <= 1'b1;
                                    wr_idx    <= ptr;
                                    ptr       <= ptr_next;
                                end
                            end
                        end else if (scl_fall && got_bit) begin
                            got_bit <= 1'b0;
                            if (state == ST_ADDR) begin
                                if (shreg[I2C_BYTE_W-1:1] == TARGET_ADDR) begin
                                    rw    <= shreg[0];
                                    ctrl  <= 1'b1;
                                    state <= ST_ADDR_ACK;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end else if (state == ST_PTR) begin
                                if (ptr_ok) begin
                                    ptr   <= shreg[PW-1:0];
                                    ctrl  <= 1'b1;
                                    state <= ST_PTR_ACK;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end else begin
                                ctrl  <= 1'b1;
                                state <= ST_WDATA_ACK;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (rw) begin
                                // First read bit goes out on the same fall that ends the ACK
                                shreg <= rd_byte;
                                ptr   <= ptr_next;
                                ctrl  <= ~rd_byte[I2C_BYTE_W-1];
                                state <= ST_RDATA;
                            end else begin
                                ctrl  <= 1'b0;
                                state <= ST_PTR;
                            end
                        end
                    end

                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            ctrl    <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= ST_WDATA;
                        end
                    end

                    ST_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                ctrl    <= 1'b0;
                                got_bit <= 1'b0;
                                state   <= ST_RACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                ctrl    <= ~shreg[I2C_BYTE_W-2];
                                shreg   <= {shreg[I2C_BYTE_W-2:0], 1'b0};
                            end
                        end
                    end

                    ST_RACK: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_NACK) begin
                                state <= ST_IGNORE;
                            end else begin
                                got_bit <= 1'b1;
                            end
                        end else if (scl_fall && got_bit) begin
                            got_bit <= 1'b0;
                            bit_cnt <= 3'd0;
                            shreg   <= rd_byte;
                            ptr     <= ptr_next;
                            ctrl    <= ~rd_byte[I2C_BYTE_W-1];
                            state   <= ST_RDATA;
                        end
                    end

                    ST_IGNORE: begin
                        ctrl <= 1'b0;
                    end

                    default: begin
                        ctrl  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - scoreboard bench for the I2C target register file
module tb_i2c_target_regfile;
    import i2c_pkg::*;

    localparam int         NREGS = 4;
    localparam logic [7:0] RV    = 8'h3C;
    localparam logic [6:0] TADDR = 7'h2A;
    localparam int         Q     = 6;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_out;
    logic       ctrl;
    logic [8*NREGS-1:0] reg_q;
    logic       wr_stb;
    logic [1:0] wr_idx;

    int         tests = 0;
    int         fails = 0;
    int         glitch_cnt = 0;
    logic       prev_ctrl = 1'b0;
    logic       ctrl_watch = 1'b0;
    logic       ctrl_seen = 1'b0;

    logic [7:0] mregs [NREGS];
    int         mptr;
    wr_t        exp_wr [$];
    wr_t        mon_e;
    logic [7:0] wbuf [8];

    assign sda_bus = m_sda & ~ctrl;

    i2c_target_regfile #(
        .TARGET_ADDR (TADDR),
        .NREGS       (NREGS),
        .RESET_VAL   (RV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (m_scl),
        .sda_in  (sda_bus),
        .sda_out (sda_out),
        .ctrl    (ctrl),
        .reg_q   (reg_q),
        .wr_stb  (wr_stb),
        .wr_idx  (wr_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8*NREGS-1:0] model_flat();
        logic [8*NREGS-1:0] r;
        for (int i = 0; i < NREGS; i++) r[8*i +: 8] = mregs[i];
        return r;
    endfunction

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_stb) begin
                if (exp_wr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wr_unexpected: wr_idx=%0d with no write expected", wr_idx);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_idx", 32'(wr_idx), 32'(mon_e.idx));
                    check("wr_data", 32'(reg_q[8*mon_e.idx +: 8]), 32'(mon_e.data));
                end
            end
            if (ctrl !== prev_ctrl && m_scl) glitch_cnt++;
            if (ctrl_watch && ctrl) ctrl_seen = 1'b1;
        end
        prev_ctrl = ctrl;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda = 1'b0;
        wait_clk(Q);
        m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q);
        m_sda = 1'b0;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        m_sda = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        wait_clk(Q);
        if (glitch) begin
            m_sda = ~b;
            wait_clk(2);
            m_sda = b;
            wait_clk(2);
            m_sda = ~b;
            wait_clk(2);
        end
        m_sda = b;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(2*Q);
        m_scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(Q);
        m_sda = 1'b1;
        wait_clk(Q);
        m_scl = 1'b1;
        wait_clk(Q);
        b = sda_bus;
        wait_clk(Q);
        m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gb, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == gb);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack_lvl, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        send_bit(ack_lvl, 1'b0);
    endtask

    task automatic do_write(input int p, input int n, input int gb);
        logic ack;
        int   q;
        i2c_start();
        send_byte({TADDR, 1'b0}, -1, ack);
        check("addr_w_ack", 32'(ack), 32'(I2C_ACK));
        send_byte(8'(p), -1, ack);
        check("ptr_ack", 32'(ack), (p < NREGS) ? 32'(I2C_ACK) : 32'(I2C_NACK));
        q = p;
        for (int k = 0; k < n; k++) begin
            if (p < NREGS) begin
                mregs[q] = wbuf[k];
                exp_wr.push_back('{q, wbuf[k]});
            end
            send_byte(wbuf[k], (k == 0) ? gb : -1, ack);
            check("data_ack", 32'(ack), (p < NREGS) ? 32'(I2C_ACK) : 32'(I2C_NACK));
            if (p < NREGS) q = (q + 1) % NREGS;
        end
        if (p < NREGS) mptr = q;
        i2c_stop();
    endtask

    task automatic do_read(input int p, input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        send_byte({TADDR, 1'b0}, -1, ack);
        check("rd_addr_w_ack", 32'(ack), 32'(I2C_ACK));
        send_byte(8'(p), -1, ack);
        check("rd_ptr_ack", 32'(ack), 32'(I2C_ACK));
        mptr = p;
        i2c_start();
        send_byte({TADDR, 1'b1}, -1, ack);
        check("addr_r_ack", 32'(ack), 32'(I2C_ACK));
        for (int k = 0; k < n; k++) begin
            read_byte((k == n - 1) ? I2C_NACK : I2C_ACK, d);
            check("rd_data", 32'(d), 32'(mregs[mptr]));
            mptr = (mptr + 1) % NREGS;
        end
        wait_clk(6);
        check("ctrl_released_after_nack", 32'(ctrl), 32'd0);
        i2c_stop();
    endtask

    initial begin
        logic ack;
        int   p;
        int   n;

        for (int i = 0; i < NREGS; i++) mregs[i] = RV;
        mptr = 0;
        rst = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(3);

        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_sda_out", 32'(sda_out), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_idx", 32'(wr_idx), 32'd0);
        check("rst_reg_q", reg_q, model_flat());

        // Pointer 1, two data bytes
        wbuf[0] = 8'h55;
        wbuf[1] = 8'hAA;
        do_write(1, 2, -1);
        check("reg_q_after_write", reg_q, model_flat());

        // Register read through a repeated START
        do_read(2, 2);

        // Foreign address: never acknowledged, nothing written
        i2c_start();
        ctrl_seen  = 1'b0;
        ctrl_watch = 1'b1;
        send_byte(8'h56, -1, ack);
        check("wrong_addr_nack", 32'(ack), 32'(I2C_NACK));
        send_byte(8'h00, -1, ack);
        check("wrong_addr_ptr_nack", 32'(ack), 32'(I2C_NACK));
        send_byte(8'h77, -1, ack);
        check("wrong_addr_data_nack", 32'(ack), 32'(I2C_NACK));
        i2c_stop();
        ctrl_watch = 1'b0;
        check("wrong_addr_ctrl_idle", 32'(ctrl_seen), 32'd0);
        check("wrong_addr_regs", reg_q, model_flat());
        wbuf[0] = 8'h11;
        do_write(0, 1, -1);

        // Pointer wrap on write, then out-of-range pointer
        wbuf[0] = 8'hD1;
        wbuf[1] = 8'hD2;
        wbuf[2] = 8'hD3;
        do_write(3, 3, -1);
        check("wrap_regs", reg_q, model_flat());
        wbuf[0] = 8'hEE;
        do_write(4, 1, -1);
        check("bad_ptr_regs", reg_q, model_flat());

        // STOP after five data bits
        i2c_start();
        send_byte({TADDR, 1'b0}, -1, ack);
        check("partial_addr_ack", 32'(ack), 32'(I2C_ACK));
        send_byte(8'h01, -1, ack);
        check("partial_ptr_ack", 32'(ack), 32'(I2C_ACK));
        mptr = 1;
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
        i2c_stop();
        check("partial_state_idle", 32'(dut.state), 32'(ST_IDLE));
        check("partial_ctrl", 32'(ctrl), 32'd0);
        check("partial_regs", reg_q, model_flat());

        // SDA toggling while SCL is low must not disturb a transfer
        wbuf[0] = 8'h5A;
        wbuf[1] = 8'hC3;
        do_write(1, 2, 3);
        check("glitch_regs", reg_q, model_flat());
        do_read(1, 2);

        // Randomised writes and reads against the model
        for (int t = 0; t < 16; t++) begin
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 0) begin
                p = $urandom_range(0, 5);
                for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                do_write(p, n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
                check("rand_regs", reg_q, model_flat());
            end else begin
                p = $urandom_range(0, NREGS - 1);
                do_read(p, n);
            end
        end

        // Reset while the target drives a read bit
        wbuf[0] = 8'h00;
        do_write(0, 1, -1);
        i2c_start();
        send_byte({TADDR, 1'b0}, -1, ack);
        send_byte(8'h00, -1, ack);
        i2c_start();
        send_byte({TADDR, 1'b1}, -1, ack);
        check("rst_rd_addr_ack", 32'(ack), 32'(I2C_ACK));
        wait_clk(6);
        check("rst_rd_drive", 32'(ctrl), 32'd1);
        rst = 1'b1;
        wait_clk(1);
        check("rst_mid_read_ctrl", 32'(ctrl), 32'd0);
        for (int i = 0; i < NREGS; i++) mregs[i] = RV;
        mptr = 0;
        check("rst_mid_read_regs", reg_q, model_flat());
        m_sda = 1'b1;
        wait_clk(2);
        m_scl = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        do_read(0, 2);

        wait_clk(10);
        check("scoreboard_drained", 32'(exp_wr.size()), 32'd0);
        check("ctrl_stable_scl_high", 32'(glitch_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Parametrised I2C target (slave) exposing a bank of `NREGS` 8-bit registers to an external I2C master, with a register pointer, auto-increment and repeated-START support. It is the next-generation replacement for the single-byte I2C minion on the Tiny Tapeout user I/O pins. SDA is driven open-drain through the bidirectional pin's output-enable. Register contents are exported flat to user logic, together with a per-write strobe.

## Interface
- `TARGET_ADDR`, default 7'h2A: 7-bit I2C target address.
- `NREGS`, default 4: number of 8-bit registers, 2..256.
- `RESET_VAL`, default 0: reset value of every register (8 bits).
- `clk` in 1: system clock; must be at least 16x the SCL frequency.
- `rst` in 1: synchronous, active-high reset.
- `scl` in 1: raw SCL pin.
- `sda_in` in 1: raw SDA pin.
- `sda_out` out 1: constant 0; the pin only ever drives low.
- `ctrl` out 1: SDA output enable (to `uio_oe`); 1 pulls SDA low.
- `reg_q` out 8*NREGS: register bank; register i is at [8i+7:8i].
- `wr_stb` out 1: one-cycle pulse when a register is written by the master.
- `wr_idx` out $clog2(NREGS): index of the register written; valid with `wr_stb`.

## Operation
- Input path:
  - `scl`/`sda_in` pass through a 2-flop synchroniser, then a history flop.
  - rise/fall = 0→1 / 1→0 on synchronised SCL.
  - START = SDA 1→0 while SCL is high on both samples; STOP = SDA 0→1 while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- Bit capture is MSB first, sampled on SCL rise. The bit counter is 0..7; byte complete = the 8th rise.
- IDLE: START → ADDR, bit count cleared.
- ADDR: 8 bits = address[7:1] and R/W̄.
  - Match: on the SCL fall after bit 8 → ADDR_ACK.
  - Mismatch → IGNORE, and `ctrl` stays 0.
- ADDR_ACK: `ctrl`=1 from that fall until the next fall. Then go to PTR (write) or RDATA (read).
- PTR: the received byte is the pointer.
  - Pointer < NREGS: load it, then PTR_ACK (ACK).
  - Otherwise: NACK (`ctrl`=0 through the 9th clock), then IGNORE.
- PTR_ACK → WDATA.
- WDATA:
  - On byte complete: write `regs[ptr]`, pulse `wr_stb` with `wr_idx`=ptr, ptr ← (ptr+1) mod NREGS.
  - Then WDATA_ACK (ACK) → WDATA.
- RDATA:
  - On entry, shift register ← `regs[ptr]`, ptr increments (mod NREGS).
  - Each bit drives `ctrl` = ~bit, applied after the SCL fall. `ctrl` is released after the 8th fall → RACK.
- RACK: sample SDA on the rise.
  - 0 (ACK): RDATA on the next fall.
  - 1 (NACK): IGNORE.
- IGNORE: `ctrl`=0; wait for START or STOP.
- Overrides, applied in every state, highest last:
  - START → ADDR, counter cleared, pointer kept (enables register-read via repeated START).
  - STOP → IDLE.
  - `rst` → IDLE, ptr=0, all regs=RESET_VAL, `ctrl`=0, `wr_stb`=0.
- Simultaneous user write is not supported: registers are master-writable only.

## Timing
- Reset values: `ctrl`=0, `sda_out`=0, `wr_stb`=0, `wr_idx`=0, `reg_q`={NREGS{RESET_VAL}}, state IDLE, ptr=0.
- Pin to internal event latency: 3 clk (2 sync + 1 edge detect).
- `ctrl` changes exactly 1 clk after the internal SCL-fall event, never while SCL is high except at the START/STOP override (forced 0).
- `wr_stb` asserts 1 clk after the internal 8th-rise event; `reg_q` updates in the same cycle.
- Pointer wrap: NREGS-1 → 0 on both write and read.
- STOP mid-byte: the partial byte is discarded, nothing is written, `ctrl` is 0 next cycle.
- `rst` mid-read: `ctrl` is 0 on the next clk.

## Structure
- Package `i2c_pkg`: FSM state enum, `I2C_ADDR_W`=7, `I2C_BYTE_W`=8, ACK/NACK level constants.
- Sub-module `i2c_bus_sync`: synchroniser, edge and START/STOP detection. Outputs `scl_rise`, `scl_fall`, `start`, `stop`, `sda_s`. Reusable by the future controller block.
- Top: FSM, bit counter, shift register, pointer, register bank.

## Test plan
- Write 0x54, 0x01, 0x55, 0xAA, STOP → ACK on all four bytes; reg1=0x55, reg2=0xAA; two `wr_stb` pulses with `wr_idx` 1 then 2.
- Write 0x54, 0x02; repeated START; 0x55, master reads 2 bytes, ACK then NACK → returns reg2 and reg3, then IGNORE; `ctrl` released after the NACK.
- Address 0x56 (wrong) → `ctrl` never asserts; no register changes; next valid transaction succeeds.
- NREGS=4: pointer 0x03, write 3 bytes → reg3, reg0, reg1 written (wrap). Pointer 0x04 → NACKed, no writes.
- STOP after 5 data bits → no `wr_stb`, state IDLE. Assert `rst` during a read bit → `ctrl`=0 next clk, regs = RESET_VAL.
- START and STOP glitches while SCL is low → ignored; the transfer in progress completes correctly.
